// File: rtl/alu_cmd_master.sv
// ============================================================================
// Module   : alu_cmd_master
// Function : valid/ready command initiator for the 4-bit registered ALU tile
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_cmd_master #(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [7:0]       alu_ui,
    output logic [7:0]       alu_uio,
    input  logic [7:0]       alu_res,
    input  logic [7:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic             rsp_overflow,
    output logic             rsp_div0,
    output logic [2:0]       rsp_op,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;
    localparam logic [2:0] c_lat     = ALU_LAT[2:0];
    localparam logic [2:0] c_op_div  = 3'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [2:0]       r_wait_cnt;
    logic [2:0]       r_op;
    logic             r_b_zero;
    logic [7:0]       r_alu_ui;
    logic [7:0]       r_alu_uio;
    logic [7:0]       r_rsp_result;
    logic             r_rsp_carry;
    logic             r_rsp_overflow;
    logic             r_rsp_div0;
    logic [2:0]       r_rsp_op;
    logic [CNT_W-1:0] r_done_count;

    logic w_cmd_fire;
    logic w_rsp_fire;
    logic w_capture;
    logic w_is_addsub;
    logic w_unused;

    assign w_cmd_fire  = cmd_valid & cmd_ready;
    assign w_rsp_fire  = rsp_valid & rsp_ready;
    assign w_capture   = (r_state == c_st_wait) && (r_wait_cnt == 3'd0);
    // The ALU only refreshes carry/overflow for ADD (0) and SUB (1).
    assign w_is_addsub = (r_op[2:1] == 2'b00);
    assign w_unused    = &{1'b0, alu_flags[5:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (w_cmd_fire) w_next = c_st_wait;
            c_st_wait: if (w_capture)  w_next = c_st_resp;
            c_st_resp: if (w_rsp_fire) w_next = c_st_idle;
            default:                   w_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (r_state)
            c_st_idle: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            c_st_resp: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: ALU pin drive, latency counter, response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt     <= 3'd0;
            r_op           <= 3'd0;
            r_b_zero       <= 1'b0;
            r_alu_ui       <= 8'd0;
            r_alu_uio      <= 8'd0;
            r_rsp_result   <= 8'd0;
            r_rsp_carry    <= 1'b0;
            r_rsp_overflow <= 1'b0;
            r_rsp_div0     <= 1'b0;
            r_rsp_op       <= 3'd0;
            r_done_count   <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_alu_ui   <= {cmd_a, cmd_b};
                r_alu_uio  <= {5'b0, cmd_op};
                r_op       <= cmd_op;
                r_b_zero   <= (cmd_b == 4'd0);
                r_wait_cnt <= c_lat;
            end else if ((r_state == c_st_wait) && (r_wait_cnt != 3'd0)) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end

            if (w_capture) begin
                r_rsp_result   <= alu_res;
                r_rsp_carry    <= w_is_addsub & alu_flags[6];
                r_rsp_overflow <= w_is_addsub & alu_flags[7];
                r_rsp_div0     <= (r_op == c_op_div) & r_b_zero;
                r_rsp_op       <= r_op;
            end

            if (w_rsp_fire) begin
                r_done_count <= r_done_count + 1'b1;
            end
        end
    end

    assign alu_ui       = r_alu_ui;
    assign alu_uio      = r_alu_uio;
    assign rsp_result   = r_rsp_result;
    assign rsp_carry    = r_rsp_carry;
    assign rsp_overflow = r_rsp_overflow;
    assign rsp_div0     = r_rsp_div0;
    assign rsp_op       = r_rsp_op;
    assign done_count   = r_done_count;

endmodule

`default_nettype wire

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Initiator for the 4-bit registered ALU tile.
- Accepts operation commands on a valid/ready interface and packs the operands and opcode onto the ALU's ui_in/uio_in pins.
- Waits a fixed ALU pipeline latency, captures the ALU result and flags, and returns one response per command on a second valid/ready interface.
- Sits between a host sequencer (or scan/test controller) and the ALU instance.

Parameters:
- ALU_LAT, 1, clock edges from the ALU's input sample edge to its result being valid on its outputs (ALU registers once per clk); legal range 1..7.
- CNT_W, 8, width of the completed-command counter.

Ports:
- clk  in  1  single clock, shared with the ALU.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  master can accept a command.
- cmd_a  in  4  operand a.
- cmd_b  in  4  operand b.
- cmd_op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT.
- alu_ui  out  8  to ALU ui_in, packed as {a,b}.
- alu_uio  out  8  to ALU uio_in, packed as {5'b0,op}.
- alu_res  in  8  from ALU uo_out.
- alu_flags  in  8  from ALU uio_out; bit7 = overflow, bit6 = carry.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  8  captured ALU result.
- rsp_carry  out  1  carry/not-borrow; ADD/SUB only, else 0.
- rsp_overflow  out  1  signed overflow; ADD/SUB only, else 0.
- rsp_div0  out  1  1 when op=DIV and b=0.
- rsp_op  out  3  opcode of this response.
- busy  out  1  high in any state other than IDLE.
- done_count  out  CNT_W  number of completed response handshakes.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; all state is reset on the clk edge where rst=1.
- Reset values: state=IDLE, cmd_ready=1, alu_ui=0, alu_uio=0, rsp_valid=0, all rsp_* fields=0, busy=0, done_count=0.
- States: IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - cmd_ready=1.
  - On the edge where cmd_valid&cmd_ready (edge E0): register alu_ui={cmd_a,cmd_b} and alu_uio={5'b0,cmd_op], latch op and the b==0 condition, load wait counter with ALU_LAT, go to WAIT.
- WAIT:
  - cmd_ready=0; alu_ui and alu_uio held stable.
  - The ALU samples at E1; the counter decrements each edge.
  - At edge E0+1+ALU_LAT: capture alu_res into rsp_result; capture flags per the masking rule; set rsp_div0; go to RESP with rsp_valid=1.
  - With ALU_LAT=1, rsp_valid rises 2 cycles after command acceptance.
- Flag masking: the ALU holds stale flags for non-ADD/SUB ops, so rsp_carry/rsp_overflow are taken from alu_flags[6]/[7] only when op is 0 or 1; otherwise they are 0.
- RESP:
  - rsp_* fields held stable while rsp_valid=1 and rsp_ready=0.
  - ALU input pins held unchanged.
  - On rsp_valid&rsp_ready: rsp_valid=0, done_count+1, go to IDLE.
  - No new command is accepted in the same cycle; cmd_ready rises the cycle after the handshake.
- Throughput: one command per (3+ALU_LAT) cycles minimum, with rsp_ready held high.
- done_count wraps from 2^CNT_W-1 to 0 with no saturation.
- cmd_valid while not ready: ignored; the command payload is not sampled.
- rst=1 mid-WAIT or mid-RESP: the pending command is discarded, no response is issued, and all outputs return to reset values on that edge.
- rst and cmd_valid in the same cycle: rst wins.
- Opcodes are not validated; all 8 values are legal.

Test Plan:
- Latency and ADD flags: reset, then ADD a=9 b=8 accepted at edge 0 -> rsp_valid=1 after edge 2; rsp_result=0x01, carry=1, overflow=1, div0=0; done_count=1 after the handshake.
- SUB borrow: a=3 b=5 -> rsp_result=0x0E, carry=0, overflow=0. Then SUB a=8 b=1 -> rsp_result=0x07, carry=1, overflow=1.
- MUL and flag masking: after the ADD above, MUL a=15 b=15 -> rsp_result=0xE1, carry=0, overflow=0, despite the ALU's stale flags being 1.
- DIV: a=13 b=4 -> rsp_result=0x13, div0=0. Then DIV a=7 b=0 -> rsp_result=0x00, div0=1.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> response fields stable, cmd_ready=0, alu_ui unchanged. Release rsp_ready -> handshake, then cmd_ready=1 on the next cycle.
- Reset mid-WAIT and counter wrap:
  - Assert rst during WAIT -> no rsp_valid, all outputs 0, done_count unchanged from reset.
  - Separately, run 256 back-to-back AND commands -> done_count wraps to 0.
